// File: rtl/bp_be_pkg.sv
// bp_be_pkg
//   Shared types for the BE FPU issue/writeback controller:
//   - FP operation, precision, rounding-mode and fflags encodings
//   - bp_be_fpu_shadow_s   : one stage of the in-flight tag pipeline
//   - bp_be_fpu_wb_entry_s : one result-buffer entry {tag, illegal, eflags, data}
//   - bp_be_frm_illegal()  : true for the reserved rounding modes 5, 6, 7
package bp_be_pkg;

   localparam int bp_tag_width_gp   = 5;
   localparam int bp_dword_width_gp = 64;

   typedef enum logic [3:0] {
      e_op_fadd    = 4'd0,
      e_op_fsub    = 4'd1,
      e_op_fmul    = 4'd2,
      e_op_fmin    = 4'd3,
      e_op_fmax    = 4'd4,
      e_op_fcvt_ff = 4'd5
   } bp_be_fp_fu_op_e;

   typedef enum logic {
      e_pr_single = 1'b0,
      e_pr_double = 1'b1
   } bp_be_fp_pr_e;

   typedef enum logic [2:0] {
      e_rne = 3'd0,
      e_rtz = 3'd1,
      e_rdn = 3'd2,
      e_rup = 3'd3,
      e_rmm = 3'd4,
      e_dyn = 3'd7
   } rv64_frm_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } rv64_fflags_s;

   typedef struct packed {
      logic                       v;
      logic [bp_tag_width_gp-1:0] tag;
      logic                       illegal;
   } bp_be_fpu_shadow_s;

   typedef struct packed {
      logic [bp_tag_width_gp-1:0]   tag;
      logic                         illegal;
      rv64_fflags_s                 eflags;
      logic [bp_dword_width_gp-1:0] data;
   } bp_be_fpu_wb_entry_s;

   // Operates on the resolved mode, so dyn (7) reaching here means the FCSR
   // itself held dyn, which is also illegal.
   function automatic logic bp_be_frm_illegal(input rv64_frm_e rm);
      return (3'(rm) > 3'd4);
   endfunction

endpackage

// File: rtl/bp_be_fpu_result_buffer.sv
// bp_be_fpu_result_buffer
//   1-read/1-write FIFO of bp_be_fpu_wb_entry_s with asynchronous active-low
//   reset and synchronous clear. Head entry is presented on data_o.
//   Ports:
//     clk_i, reset_n_i : clock, async active-low reset
//     clr_i            : synchronous clear (wins over push/pop)
//     push_i, data_i   : write strobe and entry
//     pop_i            : read strobe (ignored when empty)
//     data_o           : head entry
//     full_o, empty_o  : occupancy status
module bp_be_fpu_result_buffer
   import bp_be_pkg::*;
#(
   parameter int els_p = 4
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                clr_i,
   input  logic                push_i,
   input  bp_be_fpu_wb_entry_s data_i,
   input  logic                pop_i,
   output bp_be_fpu_wb_entry_s data_o,
   output logic                full_o,
   output logic                empty_o
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   bp_be_fpu_wb_entry_s mem_r [els_p];
   logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
   logic [cnt_w_lp-1:0] cnt_r;
   logic                push_en, pop_en;

   function automatic logic [ptr_w_lp-1:0] ptr_next(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign full_o  = (cnt_r == cnt_w_lp'(els_p));
   assign empty_o = (cnt_r == '0);
   assign push_en = push_i & ~full_o;
   assign pop_en  = pop_i & ~empty_o;
   assign data_o  = mem_r[rd_ptr_r];

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
         for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
      end else if (clr_i) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         if (push_en) begin
            mem_r[wr_ptr_r] <= data_i;
            wr_ptr_r        <= ptr_next(wr_ptr_r);
         end
         if (pop_en) rd_ptr_r <= ptr_next(rd_ptr_r);
         cnt_r <= cnt_r + cnt_w_lp'(push_en) - cnt_w_lp'(pop_en);
      end
   end

   // The credit counter upstream should make this unreachable.
   a_no_push_when_full : assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(push_i && full_o && !clr_i));

endmodule

// File: rtl/bp_be_fpu_pipe_ctrl.sv
// bp_be_fpu_pipe_ctrl
//   Issue/writeback controller for a fixed-latency, non-stallable FPU.
//   - Request side: valid/ready handshake; fpu_* are pass-through of req_*
//     with dynamic rounding mode resolved from fcsr_frm_i.
//   - Shadow pipeline of {v, tag, illegal} aligned with fpu_result_i.
//   - Result buffer (depth latency_p) holds results so a stalled writeback
//     port never loses one; a credit counter bounds in-flight + buffered ops.
//   - flush_i kills all in-flight and buffered ops.
//   - Sticky fflags accumulation, enabled by macro
//     BP_FPU_PIPE_CTRL_FFLAGS_ACCUM_EN (undefined: fflags_o = 0).
//   Parameters: latency_p (>= 2), tag_width_p and dword_width_p must equal the
//   package widths bp_tag_width_gp / bp_dword_width_gp.
module bp_be_fpu_pipe_ctrl
   import bp_be_pkg::*;
#(
   parameter int latency_p     = 4,
   parameter int tag_width_p   = bp_tag_width_gp,
   parameter int dword_width_p = bp_dword_width_gp
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,

   input  logic                     req_v_i,
   output logic                     req_ready_o,
   input  logic [tag_width_p-1:0]   req_tag_i,
   input  bp_be_fp_fu_op_e          req_op_i,
   input  bp_be_fp_pr_e             req_ipr_i,
   input  bp_be_fp_pr_e             req_opr_i,
   input  rv64_frm_e                req_frm_i,
   input  rv64_frm_e                fcsr_frm_i,

   output logic                     fpu_v_o,
   output bp_be_fp_fu_op_e          fpu_op_o,
   output bp_be_fp_pr_e             fpu_ipr_o,
   output bp_be_fp_pr_e             fpu_opr_o,
   output rv64_frm_e                fpu_rm_o,
   input  logic [dword_width_p-1:0] fpu_result_i,
   input  rv64_fflags_s             fpu_eflags_i,

   input  logic                     flush_i,

   output logic                     wb_v_o,
   input  logic                     wb_ready_i,
   output logic [tag_width_p-1:0]   wb_tag_o,
   output logic [dword_width_p-1:0] wb_data_o,
   output rv64_fflags_s             wb_eflags_o,
   output logic                     wb_illegal_o,

   output rv64_fflags_s             fflags_o,
   input  logic                     fflags_clr_i
);

   localparam int cnt_w_lp = $clog2(latency_p + 1);

   logic [cnt_w_lp-1:0] count_r;
   logic                ready_en_r;
   logic                pop;
   logic                buf_full, buf_empty;
   bp_be_fpu_shadow_s   issue_s, shadow_last;
   bp_be_fpu_wb_entry_s push_entry, head_raw, head;

   // ---------------- issue ----------------
   assign fpu_rm_o    = (req_frm_i == e_dyn) ? fcsr_frm_i : req_frm_i;
   assign req_ready_o = ready_en_r & ~flush_i & (count_r < cnt_w_lp'(latency_p));
   assign fpu_v_o     = req_v_i & req_ready_o;
   assign fpu_op_o    = req_op_i;
   assign fpu_ipr_o   = req_ipr_i;
   assign fpu_opr_o   = req_opr_i;

   always_comb begin
      issue_s         = '0;
      issue_s.v       = fpu_v_o;
      issue_s.tag     = req_tag_i;
      issue_s.illegal = bp_be_frm_illegal(fpu_rm_o);
   end

   // ---------------- shadow tag pipeline ----------------
   // The issue cycle itself is the first stage; latency_p-2 registers follow,
   // so the last stage lines up with fpu_result_i latency_p-2 cycles later.
   if (latency_p == 2) begin : g_shadow_comb
      assign shadow_last = issue_s;
   end else begin : g_shadow_pipe
      bp_be_fpu_shadow_s shadow_r [latency_p-2];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            for (int i = 0; i < latency_p-2; i++) shadow_r[i] <= '0;
         end else begin
            shadow_r[0] <= issue_s;
            for (int i = 1; i < latency_p-2; i++) shadow_r[i] <= shadow_r[i-1];
            if (flush_i) begin
               for (int i = 0; i < latency_p-2; i++) shadow_r[i].v <= 1'b0;
            end
         end
      end

      assign shadow_last = shadow_r[latency_p-3];
   end

   // ---------------- result buffer ----------------
   always_comb begin
      push_entry         = '0;
      push_entry.tag     = shadow_last.tag;
      push_entry.illegal = shadow_last.illegal;
      push_entry.eflags  = shadow_last.illegal ? '0 : fpu_eflags_i;
      push_entry.data    = fpu_result_i;
   end

   bp_be_fpu_result_buffer #(
      .els_p (latency_p)
   ) u_result_buffer (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .clr_i     (flush_i),
      .push_i    (shadow_last.v),
      .data_i    (push_entry),
      .pop_i     (wb_ready_i),
      .data_o    (head_raw),
      .full_o    (buf_full),
      .empty_o   (buf_empty)
   );

   // Mask the stale head so wb_* read as zero while nothing is buffered.
   assign head         = buf_empty ? '0 : head_raw;
   assign wb_v_o       = ~buf_empty;
   assign wb_tag_o     = head.tag;
   assign wb_data_o    = head.data;
   assign wb_eflags_o  = head.eflags;
   assign wb_illegal_o = head.illegal;
   assign pop          = wb_v_o & wb_ready_i;

   // ---------------- credit counter ----------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         count_r    <= '0;
         ready_en_r <= 1'b0;
      end else begin
         ready_en_r <= 1'b1;
         if (flush_i)               count_r <= '0;
         else if (fpu_v_o && !pop)  count_r <= count_r + cnt_w_lp'(1);
         else if (!fpu_v_o && pop)  count_r <= count_r - cnt_w_lp'(1);
      end
   end

   // ---------------- sticky fflags ----------------
`ifdef BP_FPU_PIPE_CTRL_FFLAGS_ACCUM_EN
   rv64_fflags_s fflags_r;

   // The retiring op's flags are OR'd after the clear, so they survive it.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fflags_r <= '0;
      end else begin
         fflags_r <= rv64_fflags_s'((fflags_clr_i ? 5'b0 : 5'(fflags_r))
                                    | ((pop && !head.illegal) ? 5'(head.eflags) : 5'b0));
      end
   end

   assign fflags_o = fflags_r;
`else
   assign fflags_o = '0;
   wire unused_fflags_clr = &{1'b0, fflags_clr_i};
`endif

   wire unused_buf_full = &{1'b0, buf_full};

endmodule
